calc_seq_alu: RTL and testbench

- Sequential, parametrised calculator arithmetic unit for the keypad calculator datapath.
- Accepts two N-digit decimal operands as packed BCD digits and a keypad operator code (11 add, 12 subtract, 13 multiply, 14 divide).
- Converts each operand to binary one digit per cycle, then executes the operation: one cycle for add/subtract, an iterative shift-add multiplier, and a restoring divider.
- Returns a registered result with a done pulse, a sign flag, a remainder and error flags, feeding the display/BCD formatting stage.

---
 rtl/calc_seq_alu.sv | 189 ++++++++++++++++++
 tb/tb_calc_seq_alu.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/calc_seq_alu.sv
// Sequential keypad-calculator ALU: BCD operands are converted to binary one digit per cycle,
// then added/subtracted in one cycle, multiplied by shift-add or divided by restoring division.
module calc_seq_alu #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned OPW    = 7,
  localparam int unsigned RW    = 2 * OPW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a_digits,
  input  logic [4*DIGITS-1:0]   b_digits,
  input  logic [5:0]            arithmetic,
  output logic                  busy,
  output logic                  done,
  output logic [RW-1:0]         total,
  output logic [OPW-1:0]        rem,
  output logic                  neg,
  output logic                  err_op,
  output logic                  err_digit,
  output logic                  err_div0
);

  localparam logic [5:0] OpAdd = 6'd11;
  localparam logic [5:0] OpSub = 6'd12;
  localparam logic [5:0] OpMul = 6'd13;
  localparam logic [5:0] OpDiv = 6'd14;

  localparam int unsigned CntMax = (DIGITS > OPW) ? DIGITS : OPW;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StConv, StExec, StDone} state_e;

  state_e                state_q;
  logic [4*DIGITS-1:0]   a_q, b_q;
  logic [5:0]            op_q;
  logic [OPW-1:0]        num_a_q, num_b_q, part_q;
  logic [RW-1:0]         acc_q, mcand_q;
  logic [CW-1:0]         cnt_q;
  logic                  inv_op_q, bad_dig_q, div0_q;

  logic                  bad_in;
  logic [3:0]            dig_a, dig_b;
  logic [OPW-1:0]        conv_a, conv_b;
  logic [RW-1:0]         mul_acc;
  logic [OPW:0]          shifted, trial;
  logic                  fits;
  logic [OPW-1:0]        part_next, quo_next;
  logic                  last_conv, last_exec;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_digits[4*i +: 4] > 4'd9 || b_digits[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
    dig_a   = a_q[4*DIGITS-1 -: 4];
    dig_b   = b_q[4*DIGITS-1 -: 4];
    conv_a  = num_a_q * OPW'(10) + OPW'(dig_a);
    conv_b  = num_b_q * OPW'(10) + OPW'(dig_b);
    mul_acc = acc_q + (num_b_q[0] ? mcand_q : '0);
    // Restoring step: num_a_q shifts out dividend bits MSB first and fills with quotient bits.
    shifted   = {part_q, num_a_q[OPW-1]};
    trial     = shifted - {1'b0, num_b_q};
    fits      = shifted >= {1'b0, num_b_q};
    part_next = fits ? trial[OPW-1:0] : shifted[OPW-1:0];
    quo_next  = {num_a_q[OPW-2:0], fits};
    last_conv = (cnt_q == CW'(DIGITS - 1));
    last_exec = (cnt_q == CW'(OPW - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      num_a_q   <= '0;
      num_b_q   <= '0;
      part_q    <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      inv_op_q  <= 1'b0;
      bad_dig_q <= 1'b0;
      div0_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      total     <= '0;
      rem       <= '0;
      neg       <= 1'b0;
      err_op    <= 1'b0;
      err_digit <= 1'b0;
      err_div0  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q       <= a_digits;
            b_q       <= b_digits;
            op_q      <= arithmetic;
            num_a_q   <= '0;
            num_b_q   <= '0;
            cnt_q     <= '0;
            bad_dig_q <= bad_in;
            div0_q    <= 1'b0;
            busy      <= 1'b1;
            if (arithmetic < OpAdd || arithmetic > OpDiv) begin
              inv_op_q <= 1'b1;
              state_q  <= StDone;
            end else begin
              inv_op_q <= 1'b0;
              state_q  <= StConv;
            end
          end
        end
        StConv: begin
          num_a_q <= conv_a;
          num_b_q <= conv_b;
          a_q     <= a_q << 4;
          b_q     <= b_q << 4;
          cnt_q   <= cnt_q + CW'(1);
          if (last_conv) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            part_q  <= '0;
            mcand_q <= RW'(conv_a);
            if (bad_dig_q) begin
              state_q <= StDone;
            end else if (op_q == OpDiv && conv_b == '0) begin
              div0_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StExec;
            end
          end
        end
        StExec: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q == OpAdd || op_q == OpSub || last_exec) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
            rem       <= '0;
            neg       <= 1'b0;
            err_op    <= 1'b0;
            err_digit <= 1'b0;
            err_div0  <= 1'b0;
          end
          if (op_q == OpAdd) begin
            total <= RW'(num_a_q) + RW'(num_b_q);
          end else if (op_q == OpSub) begin
            if (num_a_q >= num_b_q) begin
              total <= RW'(num_a_q - num_b_q);
            end else begin
              total <= RW'(num_b_q - num_a_q);
              neg   <= 1'b1;
            end
          end else if (op_q == OpMul) begin
            acc_q   <= mul_acc;
            mcand_q <= mcand_q << 1;
            num_b_q <= num_b_q >> 1;
            if (last_exec) total <= mul_acc;
          end else begin
            num_a_q <= quo_next;
            part_q  <= part_next;
            if (last_exec) begin
              total <= RW'(quo_next);
              rem   <= part_next;
            end
          end
        end
        StDone: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StIdle;
          total     <= '0;
          rem       <= '0;
          neg       <= 1'b0;
          err_op    <= inv_op_q;
          err_digit <= !inv_op_q && bad_dig_q;
          err_div0  <= !inv_op_q && !bad_dig_q && div0_q;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_alu.sv
// Directed self-checking bench for calc_seq_alu with DIGITS=2, OPW=7.
module tb_calc_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  a_digits, b_digits;
  logic [5:0]  arithmetic;
  logic        busy, done, neg, err_op, err_digit, err_div0;
  logic [13:0] total;
  logic [6:0]  rem;

  int n_cmp = 0;
  int n_bad = 0;

  calc_seq_alu #(.DIGITS(2), .OPW(7)) dut (
    .clk(clk), .reset(reset), .start(start), .a_digits(a_digits), .b_digits(b_digits),
    .arithmetic(arithmetic), .busy(busy), .done(done), .total(total), .rem(rem), .neg(neg),
    .err_op(err_op), .err_digit(err_digit), .err_div0(err_div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch one operation (next rising edge is E0) and check everything at the done edge.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [5:0] op, input int exp_edge, input int exp_total,
                        input int exp_rem, input bit exp_neg, input logic [2:0] exp_err);
    int edge_n;
    a_digits   = a;
    b_digits   = b;
    arithmetic = op;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    a_digits   = 8'h00;
    b_digits   = 8'h00;
    arithmetic = 6'd0;
    if (exp_edge > 1) chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    edge_n = 0;
    while (!done && edge_n < 40) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
    chk({tag, "_done_edge"}, edge_n, exp_edge);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_total"}, 32'(total), exp_total);
    chk({tag, "_rem"}, 32'(rem), exp_rem);
    chk({tag, "_neg"}, 32'(neg), 32'(exp_neg));
    chk({tag, "_err"}, 32'({err_op, err_digit, err_div0}), 32'(exp_err));
  endtask

  initial begin
    int dones;
    int first_done;
    reset      = 1'b1;
    start      = 1'b0;
    a_digits   = 8'h00;
    b_digits   = 8'h00;
    arithmetic = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'({busy, done, neg, err_op, err_digit, err_div0}), 32'd0);
    chk("reset_total", 32'(total), 32'd0);
    chk("reset_rem", 32'(rem), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("mul99", 8'h99, 8'h99, 6'd13, 9, 9801, 0, 1'b0, 3'b000);
    run_op("sub_neg", 8'h12, 8'h47, 6'd12, 3, 35, 0, 1'b1, 3'b000);
    // Issued in the done cycle of the subtract.
    run_op("add_chain", 8'h47, 8'h12, 6'd11, 3, 59, 0, 1'b0, 3'b000);
    run_op("sub_pos", 8'h50, 8'h08, 6'd12, 3, 42, 0, 1'b0, 3'b000);
    run_op("div99_7", 8'h99, 8'h07, 6'd14, 9, 14, 1, 1'b0, 3'b000);
    run_op("div_lt", 8'h03, 8'h10, 6'd14, 9, 0, 3, 1'b0, 3'b000);
    run_op("div0", 8'h05, 8'h00, 6'd14, 3, 0, 0, 1'b0, 3'b001);
    run_op("bad_digit", 8'h1A, 8'h02, 6'd11, 3, 0, 0, 1'b0, 3'b010);
    run_op("mul_zero", 8'h00, 8'h57, 6'd13, 9, 0, 0, 1'b0, 3'b000);
    run_op("bad_op", 8'h12, 8'h34, 6'd15, 1, 0, 0, 1'b0, 3'b100);
    run_op("op_and_dig", 8'h1A, 8'h34, 6'd9, 1, 0, 0, 1'b0, 3'b100);

    // Start pulses at E2 and E5 during a multiply must be ignored.
    a_digits   = 8'h23;
    b_digits   = 8'h45;
    arithmetic = 6'd13;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    first_done = 0;
    for (int e = 1; e <= 14; e++) begin
      if (e == 2 || e == 5) begin
        start      = 1'b1;
        a_digits   = 8'h11;
        b_digits   = 8'h11;
        arithmetic = 6'd11;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        dones++;
        if (first_done == 0) first_done = e;
      end
    end
    chk("ign_done_cnt", dones, 1);
    chk("ign_done_edge", first_done, 9);
    chk("ign_total", 32'(total), 32'd1035);

    // Reset sampled at E4 of a multiply aborts it.
    a_digits   = 8'h99;
    b_digits   = 8'h98;
    arithmetic = 6'd13;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_outs", 32'({busy, done, neg, err_op, err_digit, err_div0}), 32'd0);
    chk("rst_total", 32'(total), 32'd0);
    dones = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("rst_no_done", dones, 0);
    chk("rst_total_hold", 32'(total), 32'd0);
    run_op("add_after", 8'h05, 8'h06, 6'd11, 3, 11, 0, 1'b0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
